// File: rtl/connect4_pkg.sv
// Shared Connect4 encodings: game FSM state, game result and the status-animator mode set.
package connect4_pkg;

   typedef enum logic [1:0] {
      GAME_INIT = 2'b00,
      P1_TURN   = 2'b01,
      P2_TURN   = 2'b10,
      END_GAME  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      STILL_PLAYING = 2'b00,
      P1_WINS       = 2'b01,
      P2_WINS       = 2'b10,
      TIE           = 2'b11
   } status_t;

   typedef enum logic [2:0] {
      M_IDLE,
      M_TURN,
      M_ERR,
      M_WIN1,
      M_WIN2,
      M_TIE,
      M_BAD
   } mode_t;

   // Base display mode implied by the controller inputs; M_ERR is layered on top by the animator.
   function automatic mode_t decode_mode(input logic [1:0] st, input logic [1:0] gs);
      mode_t m;
      case (state_t'(st))
         GAME_INIT:        m = M_IDLE;
         P1_TURN, P2_TURN: m = M_TURN;
         default: begin
            case (status_t'(gs))
               P1_WINS: m = M_WIN1;
               P2_WINS: m = M_WIN2;
               TIE:     m = M_TIE;
               default: m = M_BAD;
            endcase
         end
      endcase
      return m;
   endfunction

endpackage

// File: rtl/connect4_status_animator_if.sv
// Controller-to-animator link: game state, result, move-error pulse and the LED bar it drives.
interface connect4_status_animator_if #(
   parameter int LED_W = 8
);
   logic [1:0]       state;
   logic [1:0]       game_status;
   logic             move_err;
   logic [LED_W-1:0] LEDs;

   modport master (output state, output game_status, output move_err, input LEDs);
   modport slave  (input state, input game_status, input move_err, output LEDs);
endinterface

// File: rtl/connect4_status_animator_tick_gen.sv
// Animation prescaler: one-cycle tick every DIV clocks; clr restarts the count at 0.
module tick_gen #(
   parameter int DIV = 25000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clr || tick) cnt <= '0;
      else                       cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/connect4_status_animator.sv
// Registered, animated game-status LED bar driver. Optional IDLE bouncing-LED attract
// animation is enabled by defining CONNECT4_ATTRACT_EN.
module connect4_status_animator
   import connect4_pkg::*;
#(
   parameter int LED_W     = 8,
   parameter int TICK_DIV  = 25000000,
   parameter int ERR_TICKS = 4
) (
   input logic                        clk,
   input logic                        rst_n,
   connect4_status_animator_if.slave  bus
);
   localparam int SW  = $clog2(LED_W + 1);
   localparam int ECW = $clog2(ERR_TICKS + 1);

   mode_t            dec, mode_q, mode_d;
   logic [SW-1:0]    step_q, step_d;
   logic [ECW-1:0]   err_q, err_d;
   logic [1:0]       state_q;
   logic [LED_W-1:0] leds_q, leds_d;
   logic             tick, clr;

   tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   // Mode selection: ERR overlays TURN until its tick budget expires or the turn owner changes.
   always_comb begin
      dec    = decode_mode(bus.state, bus.game_status);
      mode_d = dec;
      err_d  = '0;
      if (dec == M_TURN) begin
         if (mode_q == M_ERR && bus.state == state_q) begin
            mode_d = M_ERR;
            err_d  = err_q;
            if (bus.move_err) begin
               err_d = ECW'(ERR_TICKS);
            end else if (tick) begin
               err_d = err_q - ECW'(1);
               if (err_q == ECW'(1)) mode_d = M_TURN;
            end
         end else if (mode_q == M_TURN && bus.move_err) begin
            mode_d = M_ERR;
            err_d  = ECW'(ERR_TICKS);
         end
      end

      clr    = (mode_d != mode_q);
      step_d = step_q;
      if (clr) begin
         step_d = '0;
      end else if (tick) begin
         if ((mode_q == M_WIN1 || mode_q == M_WIN2) && step_q == SW'(LED_W)) step_d = '0;
         else                                                               step_d = step_q + SW'(1);
      end
   end

`ifdef CONNECT4_ATTRACT_EN
   localparam int PW = $clog2(LED_W);

   logic [PW-1:0] pos_q, pos_d;
   logic          dir_q, dir_d;  // 0 = moving towards MSB

   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      if (mode_d == M_IDLE && mode_q != M_IDLE) begin
         pos_d = '0;
         dir_d = 1'b0;
      end else if (mode_d == M_IDLE && tick) begin
         if (!dir_q) begin
            if (pos_q == PW'(LED_W - 1)) begin
               dir_d = 1'b1;
               pos_d = pos_q - PW'(1);
            end else begin
               pos_d = pos_q + PW'(1);
            end
         end else begin
            if (pos_q == '0) begin
               dir_d = 1'b0;
               pos_d = pos_q + PW'(1);
            end else begin
               pos_d = pos_q - PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_q <= '0;
         dir_q <= 1'b0;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end
`endif

   // Pattern is built from next-state values so LEDs follow inputs with one register of latency.
   always_comb begin
      leds_d = '0;
      case (mode_d)
         M_TURN: begin
            if (state_t'(bus.state) == P2_TURN) leds_d[LED_W/2]     = 1'b1;
            else                                 leds_d[LED_W/2 - 1] = 1'b1;
         end
         M_ERR, M_TIE: leds_d = step_d[0] ? '0 : '1;
         M_WIN1: begin
            for (int unsigned i = 0; i < LED_W; i++)
               leds_d[i] = (step_d != SW'(LED_W)) && (SW'(i) <= step_d);
         end
         M_WIN2: begin
            for (int unsigned i = 0; i < LED_W; i++)
               leds_d[LED_W-1-i] = (step_d != SW'(LED_W)) && (SW'(i) <= step_d);
         end
         M_BAD: begin
            for (int unsigned i = 0; i < LED_W; i++)
               leds_d[i] = i[0];
         end
`ifdef CONNECT4_ATTRACT_EN
         M_IDLE: leds_d[pos_d] = 1'b1;
`endif
         default: leds_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q  <= M_IDLE;
         step_q  <= '0;
         err_q   <= '0;
         state_q <= '0;
         leds_q  <= '0;
      end else begin
         mode_q  <= mode_d;
         step_q  <= step_d;
         err_q   <= err_d;
         state_q <= bus.state;
         leds_q  <= leds_d;
      end
   end

   assign bus.LEDs = leds_q;
endmodule

// File: tb/tb_connect4_status_animator.sv
// Scenario bench for connect4_status_animator (LED_W=8, TICK_DIV=4, ERR_TICKS=4).
module tb_connect4_status_animator;
   localparam int LED_W     = 8;
   localparam int TICK_DIV  = 4;
   localparam int ERR_TICKS = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   connect4_status_animator_if #(.LED_W(LED_W)) bus ();

   connect4_status_animator #(
      .LED_W     (LED_W),
      .TICK_DIV  (TICK_DIV),
      .ERR_TICKS (ERR_TICKS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] exp_q[$];
   logic [7:0] want;
   int checks = 0;
   int errors = 0;

   function automatic logic [7:0] bar1(input int k);
      logic [8:0] t;
      if (k >= 8) return 8'h00;
      t = (9'd1 << (k + 1)) - 9'd1;
      return t[7:0];
   endfunction

   function automatic logic [7:0] bar2(input int k);
      logic [7:0] a, r;
      a = bar1(k);
      for (int b = 0; b < 8; b++) r[7-b] = a[b];
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; bus.state = 2'b01; bus.game_status = 2'b00; bus.move_err = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) rst_n = 1'b1;
         if (i == 6) bus.state = 2'b10;
         exp_q.push_back(i < 3 ? 8'h00 : (i < 6 ? 8'h08 : 8'h10));
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL reset_turn[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
   endtask

   task automatic test_err_flash();
      bus.state = 2'b01;
      for (int i = 0; i < 20; i++) begin
         bus.move_err = (i == 1);
         if (i == 0 || i >= 17) exp_q.push_back(8'h08);
         else exp_q.push_back((((i - 1) / 4) % 2 == 0) ? 8'hFF : 8'h00);
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL err_flash[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
      bus.move_err = 1'b0;
   endtask

   task automatic test_err_reload();
      for (int i = 0; i < 23; i++) begin
         bus.move_err = (i == 0 || i == 6);
         exp_q.push_back(i < 20 ? (((i / 4) % 2 == 0) ? 8'hFF : 8'h00) : 8'h08);
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL err_reload[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
      bus.move_err = 1'b0;
   endtask

   task automatic test_err_cancel();
      for (int i = 0; i < 9; i++) begin
         bus.move_err = (i == 0);
         bus.state = (i >= 5) ? 2'b10 : 2'b01;
         exp_q.push_back(i >= 5 ? 8'h10 : (i < 4 ? 8'hFF : 8'h00));
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL err_cancel[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
      bus.move_err = 1'b0;
   endtask

   task automatic test_win1();
      bus.state = 2'b11; bus.game_status = 2'b01;
      for (int i = 0; i < 40; i++) begin
         bus.move_err = (i == 2 || i == 5);
         exp_q.push_back(bar1((i / 4) % 9));
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL win1[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
      bus.move_err = 1'b0;
   endtask

   task automatic test_win2_tie_bad();
      for (int i = 0; i < 76; i++) begin
         if (i < 40) begin
            bus.game_status = 2'b10; exp_q.push_back(bar2((i / 4) % 9));
         end else if (i < 64) begin
            bus.game_status = 2'b11; exp_q.push_back((((i - 40) / 4) % 2 == 0) ? 8'hFF : 8'h00);
         end else begin
            bus.game_status = 2'b00; exp_q.push_back(8'hAA);
         end
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL win2_tie_bad[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
   endtask

   task automatic test_mode_change();
      bus.game_status = 2'b01;
      for (int i = 0; i < 32; i++) begin
         bus.state = (i >= 21 && i < 24) ? 2'b10 : 2'b11;
         if (i < 21)      exp_q.push_back(bar1(i / 4));
         else if (i < 24) exp_q.push_back(8'h10);
         else             exp_q.push_back(bar1((i - 24) / 4));
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL mode_change[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
   endtask

   task automatic test_reset_mid_tie();
      bus.state = 2'b11; bus.game_status = 2'b11;
      for (int i = 0; i < 10; i++) begin
         rst_n = !(i == 6 || i == 7);
         if (i >= 8) bus.state = 2'b01;
         if (i < 6)      exp_q.push_back(i < 4 ? 8'hFF : 8'h00);
         else if (i < 8) exp_q.push_back(8'h00);
         else            exp_q.push_back(8'h08);
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL reset_mid_tie[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
   endtask

`ifdef CONNECT4_ATTRACT_EN
   task automatic test_attract();
      int k;
      bus.state = 2'b00;
      for (int i = 0; i < 64; i++) begin
         bus.move_err = (i == 9);
         k = (i / 4) % 14;
         exp_q.push_back(8'h01 << (k < 8 ? k : 14 - k));
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL attract[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
      bus.move_err = 1'b0;
   endtask
`else
   task automatic test_idle();
      for (int i = 0; i < 16; i++) begin
         bus.state = (i < 12) ? 2'b00 : 2'b01;
         bus.move_err = (i == 3 || i == 11);
         exp_q.push_back(i < 12 ? 8'h00 : 8'h08);
         @(posedge clk); #1;
         want = exp_q.pop_front(); checks++;
         if (bus.LEDs !== want) begin
            errors++; $display("FAIL idle[%0d]: LEDs=%b expected %b", i, bus.LEDs, want);
         end
      end
      bus.move_err = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_err_flash();
      test_err_reload();
      test_err_cancel();
      test_win1();
      test_win2_tie_bad();
      test_mode_change();
      test_reset_mid_tie();
`ifdef CONNECT4_ATTRACT_EN
      test_attract();
`else
      test_idle();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/connect4_status_animator.md
Name: connect4_status_animator

Overview:
- Registered, animated successor to the combinational game-status LED decoder.
- Drives a parametrised LED bar from the game-control FSM state, the game result and a move-error pulse.
- Adds a tick prescaler, win/tie animations and error flashing.
- Sits between the Connect4 top-level controller and the board LED pins.

Parameters:
- LED_W, 8: number of LEDs. Must be even and >= 4.
- TICK_DIV, 25000000: clk cycles per animation step. Must be >= 2.
- ERR_TICKS, 4: ticks of error flash per move_err pulse. Must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- state  in  2  game FSM state: 00 GAME_INIT, 01 P1_TURN, 10 P2_TURN, 11 END_GAME
- game_status  in  2  result: 00 STILL_PLAYING, 01 P1_WINS, 10 P2_WINS, 11 TIE
- move_err  in  1  single-cycle pulse: rejected move (column full)
- LEDs  out  LED_W  registered LED drive, 1 = lit

Behaviour:
- Reset: one clock, reset is synchronous and active-low.
  - rst_n low on a rising edge clears LEDs, prescaler, step counter and error counter.
  - Mode goes to M_IDLE.
  - Reset mid-animation aborts the animation immediately.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick is asserted for one cycle when count = TICK_DIV-1.
  - Width is $clog2(TICK_DIV).
- Mode register:
  - Modes are M_IDLE, M_TURN, M_ERR, M_WIN1, M_WIN2, M_TIE, M_BAD.
  - Decoded each cycle from state/game_status: 00→IDLE; 01/10→TURN; 11 with status 01→WIN1, 10→WIN2, 11→TIE, 00→BAD.
  - Any change of decoded mode clears the prescaler and step counter in the same cycle, so a new animation always starts at step 0.
- Error flash:
  - move_err while in M_TURN enters M_ERR and loads err_cnt = ERR_TICKS.
  - err_cnt decrements on each tick; at 0 the block returns to M_TURN.
  - move_err during M_ERR reloads err_cnt to ERR_TICKS.
  - move_err in any other mode is ignored.
  - A state change during M_ERR cancels the flash.
- Step counter:
  - Width $clog2(LED_W+1); advances on tick.
  - Wraps from LED_W to 0 in WIN modes.
  - In TIE and ERR only bit 0 is used.
- LED patterns (registered; LEDs update one cycle after the mode/step change):
  - IDLE: all off.
  - TURN, P1: only bit LED_W/2-1 lit. TURN, P2: only bit LED_W/2 lit.
  - ERR: all on when step[0]=0, all off when step[0]=1; first flash phase is all on.
  - WIN1: bar growing from LSB: bits [step:0] lit for step 0..LED_W-1. Step LED_W shows all off, then wraps.
  - WIN2: mirror of WIN1 from MSB: bits [LED_W-1:LED_W-1-step].
  - TIE: all on / all off alternating each tick, starting all on.
  - BAD: static alternating pattern, LSB off (8'b10101010 for LED_W=8).
- Latency: input change to LEDs update is 1 cycle. Animation steps occur every TICK_DIV cycles.

Optional Feature:
- Macro: CONNECT4_ATTRACT_EN.
- Defined: in M_IDLE a single lit LED bounces.
  - Position 0→LED_W-1→0, one position per tick.
  - Direction bit reverses at the ends; each end LED is shown once per bounce.
  - Position and direction reset to 0/up on entry to IDLE.
- Undefined: M_IDLE shows all off, and no position/direction registers exist.

Decomposition:
- Shared package connect4_pkg holds:
  - state encodings (GAME_INIT, P1_TURN, P2_TURN, END_GAME);
  - game_status encodings (STILL_PLAYING, P1_WINS, P2_WINS, TIE);
  - the internal mode enum.
- The prescaler is one natural sub-module, tick_gen, parameter DIV, ports clk/rst_n/clr/tick. It is reused later by the turn timer.
- Pattern generation stays in the top module.

Test Plan:
- Reset and turns, TICK_DIV=4, LED_W=8:
  - Hold rst_n=0 → LEDs=00000000.
  - Release with state=01 → LEDs=00001000 one cycle later.
  - state=10 → LEDs=00010000.
- Error flash:
  - In P1_TURN pulse move_err with ERR_TICKS=4 → LEDs show 11111111, 00000000, 11111111, 00000000, each 4 cycles, then 00001000.
  - Second pulse mid-flash restarts the 4-tick count.
- P1 win:
  - state=11, status=01 → 00000001, 00000011, … 11111111, 00000000, 00000001, each held 4 cycles.
- P2 win and tie:
  - status=10 → 10000000, 11000000, …
  - status=11 → 11111111/00000000 toggling every 4 cycles.
  - status=00 in END_GAME → steady 10101010.
- Mode change and reset:
  - Switch from WIN1 at step 5 to P2_TURN → 00010000 next cycle.
  - Return to WIN1 → restarts at 00000001.
  - rst_n=0 mid-TIE → 00000000 next cycle.
- CONNECT4_ATTRACT_EN:
  - GAME_INIT → single LED walks bit0→bit7→bit0, one step per tick.
  - Without the macro → constant 00000000.
